// File: rtl/cskipa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cskipa_pkg                                                      |
// | Desc     : Shared defaults and controller state encoding for the           |
// |            wide-operand sequenced carry-skip adder.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package cskipa_pkg;

    localparam int c_def_total_w = 96;
    localparam int c_def_slice_w = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : cskipa_pkg
`default_nettype wire

// File: rtl/cskipa_slice_cin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cskipa_slice_cin                                                |
// | Desc     : Combinational SLICE_W-bit carry-skip adder built from 4-bit     |
// |            ripple groups with per-group skip muxes and a real carry-in.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cskipa_slice_cin #(
    parameter int SLICE_W = 24
) (
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    localparam int GROUPS = SLICE_W / 4;

    if (SLICE_W % 4 != 0) begin : g_chk_slice_w
        $error("cskipa_slice_cin: SLICE_W must be a multiple of 4");
    end

    logic w_c;
    logic w_gc;
    logic w_gp;
    logic w_p;

    // w_c carries between groups; a fully-propagating group forwards its
    // incoming carry directly instead of waiting for its ripple chain.
    always_comb begin
        o_sum = '0;
        w_c   = i_cin;
        w_gc  = 1'b0;
        w_gp  = 1'b0;
        w_p   = 1'b0;
        for (int g = 0; g < GROUPS; g++) begin
            w_gc = w_c;
            w_gp = 1'b1;
            for (int b = 0; b < 4; b++) begin
                w_p              = i_a[4*g+b] ^ i_b[4*g+b];
                o_sum[4*g+b]     = w_p ^ w_gc;
                w_gc             = (i_a[4*g+b] & i_b[4*g+b]) | (w_p & w_gc);
                w_gp             = w_gp & w_p;
            end
            w_c = w_gp ? w_c : w_gc;
        end
        o_cout = w_c;
    end

endmodule : cskipa_slice_cin
`default_nettype wire

// File: rtl/cskipa_wide_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cskipa_wide_seq                                                 |
// | Desc     : Wide adder controller reusing one carry-skip slice over         |
// |            NUM_SLICES cycles, LSB first. Define CSKIPA_WIDE_SEQ_SUB_EN to  |
// |            add the i_sub port (A-B via inverted B and carry-in of 1).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cskipa_wide_seq
    import cskipa_pkg::*;
#(
    parameter int TOTAL_W = c_def_total_w,
    parameter int SLICE_W = c_def_slice_w
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [TOTAL_W-1:0] i_add_term1,
    input  logic [TOTAL_W-1:0] i_add_term2,
`ifdef CSKIPA_WIDE_SEQ_SUB_EN
    input  logic               i_sub,
`endif
    output logic               o_valid,
    input  logic               i_ready,
    output logic [TOTAL_W-1:0] o_sum,
    output logic               o_cout,
    output logic               o_busy
);

    localparam int NUM_SLICES = TOTAL_W / SLICE_W;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int IDX_W      = $clog2(TOTAL_W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_SLICES - 1);

    if (TOTAL_W % SLICE_W != 0) begin : g_chk_total_w
        $error("cskipa_wide_seq: TOTAL_W must be a multiple of SLICE_W");
    end
    if (NUM_SLICES < 2) begin : g_chk_num_slices
        $error("cskipa_wide_seq: NUM_SLICES must be at least 2");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [TOTAL_W-1:0] r_a;
    logic [TOTAL_W-1:0] r_b;
    logic [TOTAL_W-1:0] r_sum;
    logic               r_cout;
    logic               w_last;
    logic               w_accept;
    logic               w_cin_init;
    logic               w_b_inv;
    logic [IDX_W-1:0]   w_lo;
    logic [SLICE_W-1:0] w_a_sl;
    logic [SLICE_W-1:0] w_b_sl;
    logic [SLICE_W-1:0] w_sl_sum;
    logic               w_sl_cout;

`ifdef CSKIPA_WIDE_SEQ_SUB_EN
    logic r_sub;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= i_sub;
        end
    end

    assign w_cin_init = i_sub;
    assign w_b_inv    = r_sub;
`else
    assign w_cin_init = 1'b0;
    assign w_b_inv    = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && i_valid;
    assign w_last   = (r_cnt == C_LAST);
    assign w_lo     = IDX_W'(r_cnt * SLICE_W);
    assign w_a_sl   = r_a[w_lo +: SLICE_W];
    assign w_b_sl   = r_b[w_lo +: SLICE_W] ^ {SLICE_W{w_b_inv}};

    cskipa_slice_cin #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .i_a    (w_a_sl),
        .i_b    (w_b_sl),
        .i_cin  (r_carry),
        .o_sum  (w_sl_sum),
        .o_cout (w_sl_cout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_next_state = RUN;
            RUN:     if (w_last)  w_next_state = DONE;
            DONE:    if (i_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Result bits are only updated in RUN, so DONE holds them under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_carry <= w_cin_init;
            r_a     <= i_add_term1;
            r_b     <= i_add_term2;
        end else if (r_state == RUN) begin
            r_sum[w_lo +: SLICE_W] <= w_sl_sum;
            r_carry                <= w_sl_cout;
            if (w_last) begin
                r_cout <= w_sl_cout;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_ready = (r_state == IDLE);
    assign o_valid = (r_state == DONE);
    assign o_busy  = (r_state != IDLE);
    assign o_sum   = r_sum;
    assign o_cout  = r_cout;

endmodule : cskipa_wide_seq
`default_nettype wire

// File: tb/tb_cskipa_wide_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cskipa_wide_seq                                              |
// | Desc     : Scoreboard bench for cskipa_wide_seq (96/24 defaults); the      |
// |            subtract scenario runs when CSKIPA_WIDE_SEQ_SUB_EN is defined.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cskipa_wide_seq;

    typedef struct packed {
        logic [95:0] sum;
        logic        cout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [95:0] term1;
    logic [95:0] term2;
    logic        sub_in;
    logic        o_valid;
    logic        i_ready;
    logic [95:0] o_sum;
    logic        o_cout;
    logic        o_busy;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cskipa_wide_seq dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (term1),
        .i_add_term2 (term2),
`ifdef CSKIPA_WIDE_SEQ_SUB_EN
        .i_sub       (sub_in),
`endif
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
        .o_busy      (o_busy)
    );

    // Drives one accepted request; returns at the negedge after the accept edge.
    task automatic send(input logic [95:0] a, input logic [95:0] b, input logic sub);
        logic [96:0] full;
        full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {96'd0, sub};
        @(negedge clk);
        i_valid = 1'b1;
        term1   = a;
        term2   = b;
        sub_in  = sub;
        @(negedge clk);
        i_valid = 1'b0;
        term1   = {$urandom(), $urandom(), $urandom()};
        term2   = {$urandom(), $urandom(), $urandom()};
        sub_in  = 1'b0;
        sb.push_back('{sum: full[95:0], cout: full[96]});
    endtask

    task automatic wait_valid(output int cycles, output bit ok);
        cycles = 0;
        while (!o_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        ok = o_valid;
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready); else n_pass++;
        n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
        n_total++; if (o_sum !== 96'd0) $display("FAIL reset_sum: got %h want 0", o_sum); else n_pass++;
        n_total++; if (o_cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", o_cout); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int   cyc;
        bit   ok;
        exp_t e;
        send(96'd1, 96'd2, 1'b0);
        n_total++; if (o_busy !== 1'b1 || o_ready !== 1'b0) $display("FAIL basic_busy: got busy=%b ready=%b want 1/0", o_busy, o_ready); else n_pass++;
        wait_valid(cyc, ok);
        e = sb.pop_front();
        n_total++; if (!ok || cyc != 4) $display("FAIL basic_latency: got %0d cycles (valid=%b) want 4", cyc, ok); else n_pass++;
        n_total++; if (o_sum !== e.sum) $display("FAIL basic_sum: got %h want %h", o_sum, e.sum); else n_pass++;
        n_total++; if (o_cout !== e.cout) $display("FAIL basic_cout: got %b want %b", o_cout, e.cout); else n_pass++;
        consume();
        n_total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) $display("FAIL basic_release: got ready=%b valid=%b want 1/0", o_ready, o_valid); else n_pass++;
    endtask

    task automatic test_carry(input logic [95:0] a, input logic [95:0] b, input string name);
        int   cyc;
        bit   ok;
        exp_t e;
        send(a, b, 1'b0);
        wait_valid(cyc, ok);
        e = sb.pop_front();
        n_total++; if (!ok) $display("FAIL %s_timeout: got no o_valid want o_valid within 20 cycles", name); else n_pass++;
        n_total++; if (o_sum !== e.sum) $display("FAIL %s_sum: got %h want %h", name, o_sum, e.sum); else n_pass++;
        n_total++; if (o_cout !== e.cout) $display("FAIL %s_cout: got %b want %b", name, o_cout, e.cout); else n_pass++;
        consume();
    endtask

    task automatic test_backpressure();
        int   cyc;
        bit   ok;
        bit   seen;
        exp_t e;
        send(96'h1234_5678_9ABC_DEF0_1357_9BDF, 96'h0FED_CBA9_8765_4321_2468_ACE0, 1'b0);
        wait_valid(cyc, ok);
        e = sb.pop_front();
        n_total++; if (!ok) $display("FAIL bp_timeout: got no o_valid want o_valid"); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            i_valid = (i == 2);
            @(negedge clk);
            n_total++; if (o_sum !== e.sum || o_cout !== e.cout) $display("FAIL bp_hold%0d: got %h/%b want %h/%b", i, o_sum, o_cout, e.sum, e.cout); else n_pass++;
            n_total++; if (o_ready !== 1'b0 || o_valid !== 1'b1) $display("FAIL bp_state%0d: got ready=%b valid=%b want 0/1", i, o_ready, o_valid); else n_pass++;
        end
        i_valid = 1'b0;
        consume();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid || o_busy) seen = 1'b1;
            @(negedge clk);
        end
        n_total++; if (seen) $display("FAIL bp_pulse_dropped: got busy/valid after release want idle"); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int   cyc;
        bit   ok;
        bit   seen;
        exp_t e;
        send({3{32'hFFFF_FFFF}}, 96'd5, 1'b0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) $display("FAIL rstrun_state: got valid=%b ready=%b want 0/1", o_valid, o_ready); else n_pass++;
        n_total++; if (o_sum !== 96'd0 || o_busy !== 1'b0) $display("FAIL rstrun_clear: got sum=%h busy=%b want 0/0", o_sum, o_busy); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_total++; if (seen) $display("FAIL rstrun_no_valid: got o_valid pulse want none"); else n_pass++;
        send(96'd7, 96'd8, 1'b0);
        wait_valid(cyc, ok);
        e = sb.pop_front();
        n_total++; if (!ok || o_sum !== e.sum || e.sum !== 96'd15) $display("FAIL rstrun_next: got %h (valid=%b) want %h", o_sum, ok, e.sum); else n_pass++;
        consume();
    endtask

    task automatic test_random(input int n, input bit allow_sub);
        int          cyc;
        bit          ok;
        exp_t        e;
        logic [95:0] a;
        logic [95:0] b;
        logic        s;
        for (int i = 0; i < n; i++) begin
            a = {$urandom(), $urandom(), $urandom()};
            b = {$urandom(), $urandom(), $urandom()};
            if (i % 3 == 0) a[47:0] = '1;
            s = allow_sub ? 1'($urandom_range(0, 1)) : 1'b0;
            send(a, b, s);
            wait_valid(cyc, ok);
            e = sb.pop_front();
            n_total++; if (!ok || cyc != 4) $display("FAIL rand%0d_latency: got %0d (valid=%b) want 4", i, cyc, ok); else n_pass++;
            n_total++; if (o_sum !== e.sum || o_cout !== e.cout) $display("FAIL rand%0d_result: got %h/%b want %h/%b", i, o_sum, o_cout, e.sum, e.cout); else n_pass++;
            consume();
        end
    endtask

`ifdef CSKIPA_WIDE_SEQ_SUB_EN
    task automatic test_sub();
        int   cyc;
        bit   ok;
        exp_t e;
        send(96'd7, 96'd5, 1'b1);
        wait_valid(cyc, ok);
        e = sb.pop_front();
        n_total++; if (!ok || o_sum !== 96'd2 || o_cout !== 1'b1 || e.sum !== 96'd2) $display("FAIL sub_7m5: got %h/%b want 2/1", o_sum, o_cout); else n_pass++;
        consume();
        send(96'd5, 96'd7, 1'b1);
        wait_valid(cyc, ok);
        e = sb.pop_front();
        n_total++; if (!ok || o_sum !== e.sum || o_cout !== 1'b0) $display("FAIL sub_5m7: got %h/%b want %h/0", o_sum, o_cout, e.sum); else n_pass++;
        consume();
    endtask
`endif

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        term1   = '0;
        term2   = '0;
        sub_in  = 1'b0;
        test_reset();
        test_basic();
        test_carry({3{32'hFFFF_FFFF}}, 96'd1, "carry_all");
        test_carry(96'h00FF_FFFF, 96'd1, "carry_s1");
        test_backpressure();
        test_reset_mid_run();
`ifdef CSKIPA_WIDE_SEQ_SUB_EN
        test_sub();
        test_random(8, 1'b1);
`else
        test_random(8, 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_cskipa_wide_seq
`default_nettype wire
